// File: rtl/word_add_seq_if.sv
// ---------------------------------------------------------------------------
// word_add_seq_if
// Handshake/data bundle for the byte-serial adder/subtractor.
//   start : request one operation (sampled only while the engine is idle)
//   sub   : 0 = a+b, 1 = a-b (sampled with start)
//   a, b  : operands, 8*NBYTES bits (sampled with start)
//   busy  : operation in progress
//   done  : one-cycle completion pulse; sum/cout/ovf valid from here on
//   sum   : result register
//   cout  : carry out of the MSB slice (subtract: 1 = no borrow)
//   ovf   : two's-complement overflow of the full-width result
// master = requester side, slave = engine side.
// ---------------------------------------------------------------------------
interface word_add_seq_if #(
    parameter int NBYTES = 4
);
    logic                  start;
    logic                  sub;
    logic [8*NBYTES-1:0]   a;
    logic [8*NBYTES-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [8*NBYTES-1:0]   sum;
    logic                  cout;
    logic                  ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/word_add_seq.sv
// ---------------------------------------------------------------------------
// word_add_seq
// Byte-serial adder/subtractor: one 8-bit ripple slice (add8) processes one
// byte of the latched operands per clock, LSB first, with the carry held in
// a register between slices.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : word_add_seq_if.slave (start/sub/a/b in, busy/done/sum/cout/ovf out)
// Timing: start sampled in IDLE -> NBYTES RUN cycles -> one DONE cycle.
// ---------------------------------------------------------------------------

// 8-bit ripple-carry adder slice.
module add8 (
    output logic [7:0] out,
    output logic       cout,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin
);
    // Bitwise ripple chain; the carry is a block-local variable.
    always_comb begin : ripple
        logic carry;
        carry = cin;
        out   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            out[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

module word_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    word_add_seq_if.slave   bus
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    // One-hot so busy/done are direct flop bits.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;        // B' : b already inverted for subtract
    logic [W-1:0]       sum_r;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic               ovf_r;
    logic               busy_s;
    logic               done_s;
    logic               last_s;
    logic [7:0]         slice_a_s;
    logic [7:0]         slice_b_s;
    logic [7:0]         slice_sum_s;
    logic               slice_cout_s;

    assign last_s    = (idx_r == LAST_IDX);
    assign slice_a_s = a_r[32'(idx_r) * 32'd8 +: 8];
    assign slice_b_s = b_r[32'(idx_r) * 32'd8 +: 8];

    add8 u_add8 (
        .out  (slice_sum_s),
        .cout (slice_cout_s),
        .a    (slice_a_s),
        .b    (slice_b_s),
        .cin  (carry_r)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; DONE always returns to IDLE so start there is ignored.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the one-hot state register.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            ST_RUN:  busy_s = 1'b1;
            ST_DONE: done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture at start, one result byte per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            idx_r   <= '0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b ^ {W{bus.sub}};
                        carry_r <= bus.sub;      // +1 completes two's complement
                        idx_r   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_r[32'(idx_r) * 32'd8 +: 8] <= slice_sum_s;
                    carry_r <= slice_cout_s;
                    if (last_s) begin
                        idx_r <= '0;
                        // Like-signed operands whose result sign differs.
                        ovf_r <= (a_r[W-1] == b_r[W-1]) &&
                                 (slice_sum_s[7] != a_r[W-1]);
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    assign bus.busy = busy_s;
    assign bus.done = done_s;
    assign bus.sum  = sum_r;
    assign bus.cout = carry_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: doc/word_add_seq.md
WORD_ADD_SEQ -- requirements
Module: word_add_seq

Interface
REQ-001 Parameter NBYTES, default 4: number of 8-bit byte slices per operand; legal range 2..8.
REQ-002 Port clk  input  1: single clock; all state updates on rising edge.
REQ-003 Port rst  input  1: reset, asynchronous, active-high.
REQ-004 Port start  input  1: request to begin one multi-byte operation; sampled only in IDLE.
REQ-005 Port sub  input  1: 0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 Port a  input  8*NBYTES: operand A; sampled with start.
REQ-007 Port b  input  8*NBYTES: operand B; sampled with start.
REQ-008 Port busy  output  1: high while an operation is in progress (state RUN).
REQ-009 Port done  output  1: one-cycle pulse; sum/cout/ovf valid from this cycle on.
REQ-010 Port sum  output  8*NBYTES: result register.
REQ-011 Port cout  output  1: carry out of the MSB slice; in subtract mode 1 = no borrow.
REQ-012 Port ovf  output  1: two's-complement signed overflow of the full-width result.

Function
REQ-013 The block SHALL compute the result with exactly one instance of the existing 8-bit ripple adder (out, cout, a, b, cin port order), one byte slice per clock; no wider adder SHALL be inferred.
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE: start=1 at a rising edge SHALL latch a, b XOR {8*NBYTES{sub}}, carry register := sub, byte index := 0, and move to RUN.
REQ-016 RUN: each edge SHALL write the adder output into sum byte[index], load the adder cout into the carry register, and increment index; adder cin = carry register, adder operands = byte[index] of the latched A and B'.
REQ-017 RUN SHALL last exactly NBYTES cycles; the edge writing byte NBYTES-1 SHALL move to DONE.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE unconditionally; start in DONE SHALL be ignored.
REQ-019 Latency: done SHALL be high in the cycle following the NBYTES-th edge after the edge that sampled start (i.e. NBYTES+1 cycles start-to-done, minimum issue interval NBYTES+2 cycles).
REQ-020 start, a, b, sub changes while busy=1 SHALL have no effect on the operation in flight.
REQ-021 cout SHALL equal the final carry register; ovf SHALL be 1 iff latched A[MSB] = B'[MSB] and sum[MSB] differs from A[MSB].
REQ-022 sum, cout, ovf SHALL hold their values from DONE until the next accepted start; during RUN sum SHALL update byte by byte and is not valid.
REQ-023 Index wrap: index SHALL never exceed NBYTES-1; carry register SHALL be reloaded (never carried over) at each accepted start.

Reset
REQ-024 rst=1 SHALL immediately, independent of clk, force state IDLE, index 0, carry 0, sum 0, cout 0, ovf 0, busy 0, done 0.
REQ-025 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; first start after rst release SHALL be accepted normally.

Verification (NBYTES=4)
REQ-026 a=0x000000FF, b=0x00000001, sub=0 -> done 5 cycles after start sampled; sum=0x00000100, cout=0, ovf=0.
REQ-027 a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0x00000000, cout=1, ovf=0 (carry ripples through all 4 slices).
REQ-028 a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-029 a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
REQ-030 start pulsed again with new operands during RUN and in DONE -> ignored, result of first operation unchanged, exactly one done pulse.
REQ-031 rst asserted after 2 RUN edges (asynchronously, between edges) -> busy, done, sum, cout, ovf all 0 immediately; no done pulse; next start yields correct result.
